// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Optional hold-timeout feature is enabled by RR_ARB_HOLD_TIMEOUT_EN.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int HOLD_W = 8;

    // Index width that never collapses to zero bits.
    function automatic int IDW(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by ptr, fixed priority, rotate back.
// Used by rr_burst_arbiter (see RR_ARB_HOLD_TIMEOUT_EN there).
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = IDW(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_win_oh,
    output logic [IW-1:0]    o_win_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [N_REQ-1:0]   w_fix_oh;
    logic [2*N_REQ-1:0] w_back;
    logic [IW-1:0]      w_fidx;
    logic [IW:0]        w_sum;

    assign w_dbl    = {i_req, i_req} >> i_ptr;
    assign w_rot    = w_dbl[N_REQ-1:0];
    assign w_fix_oh = w_rot & (~w_rot + N_REQ'(1));
    assign w_back   = {w_fix_oh, w_fix_oh} << i_ptr;
    assign o_win_oh = w_back[2*N_REQ-1:N_REQ];
    assign o_any    = |i_req;

    always_comb begin
        w_fidx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_fidx = IW'(i);
        end
    end

    // Undo the rotation on the index: (fixed index + ptr) mod N_REQ.
    assign w_sum     = {1'b0, w_fidx} + {1'b0, i_ptr};
    assign o_win_idx = (w_sum >= (IW+1)'(N_REQ))
                     ? IW'(w_sum - (IW+1)'(N_REQ))
                     : w_sum[IW-1:0];

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst ownership and an idle gap between owners.
// Define RR_ARB_HOLD_TIMEOUT_EN to revoke ownership after MAX_HOLD cycles.
module rr_burst_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_an,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        grant,
    output logic                    grant_valid,
    output logic [IDW(N_REQ)-1:0]   grant_id,
    output logic                    timeout
);

    localparam int IW = IDW(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("rr_burst_arbiter: parameter out of range");
    end

    state_t           r_state, w_state_nx;
    logic [N_REQ-1:0] r_grant, w_grant_nx;
    logic [IW-1:0]    r_id, w_id_nx;
    logic [IW-1:0]    r_ptr, w_ptr_nx;
    logic [IW-1:0]    w_ptr_inc;
    logic             r_gv;
    logic [N_REQ-1:0] w_win_oh;
    logic [IW-1:0]    w_win_idx;
    logic             w_any;
    logic             w_release;
    logic             w_limit;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    assign w_release = done[r_id] | ~req[r_id];
    assign w_ptr_inc = (r_id == IW'(N_REQ - 1)) ? '0 : r_id + IW'(1);

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0] r_cnt, w_cnt_nx;
    logic              r_timeout, w_to_nx;

    assign w_limit = (r_cnt == HOLD_W'(MAX_HOLD));
    assign timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_timeout <= w_to_nx;
        end
    end
`else
    assign w_limit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_id_nx    = r_id;
        w_ptr_nx   = r_ptr;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        w_cnt_nx   = r_cnt;
        w_to_nx    = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx = BUSY;
                    w_grant_nx = w_win_oh;
                    w_id_nx    = w_win_idx;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                    w_cnt_nx   = HOLD_W'(1);
`endif
                end
            end
            BUSY: begin
                if (w_release || w_limit) begin
                    w_state_nx = IDLE;
                    w_grant_nx = '0;
                    w_ptr_nx   = w_ptr_inc;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                    w_cnt_nx   = '0;
                    w_to_nx    = ~w_release;
`endif
                end else begin
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                    w_cnt_nx   = r_cnt + HOLD_W'(1);
`endif
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gv    <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_gv    <= |w_grant_nx;
            r_id    <= w_id_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_gv;
    assign grant_id    = r_id;

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin arbiter that shares one downstream resource among `N_REQ` requesters with burst ownership: a winner keeps the registered grant until it signals completion or withdraws its request. Rotating priority gives the last owner the lowest priority on the next arbitration, and a mandatory idle cycle between owners guarantees that no requester is granted twice in a row while others wait. It sits between the requester ports and the shared bus/datapath mux, and its `grant_id` drives the mux select directly.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 16: maximum cycles of one ownership before forced revoke (used only with the timeout feature); legal range 2..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_an` input 1: reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `req` input N_REQ: level request per requester.
- `done` input N_REQ: one-cycle release pulse per requester; honoured only for the current owner.
- `grant` output N_REQ: registered one-hot grant, or all zero.
- `grant_valid` output 1: OR of `grant`, registered.
- `grant_id` output clog2(N_REQ): index of the owner; holds the last owner while `grant_valid`=0.
- `timeout` output 1: one-cycle pulse on forced revoke.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If any `req` bit is set, pick winner k as the first set bit searching `ptr`, `ptr`+1, … modulo N_REQ.
  - Next cycle: `grant`=1<<k, `grant_id`=k, state BUSY.
  - If no request, stay in IDLE.
- BUSY, release condition: `done[owner]`=1 or `req[owner]`=0.
- BUSY, on release:
  - Next cycle: `grant`=0, state IDLE, `ptr`=(owner+1) mod N_REQ.
- BUSY, no release: hold `grant` unchanged. Requests from other requesters do not preempt the owner.
- `done` from non-owners is ignored in every state.
- `done` in IDLE is ignored.
- Pointer wraps from N_REQ-1 to 0.
- Reset: `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0, `ptr`=0, state IDLE, hold counter 0. A reset during BUSY drops the grant on that same edge. No release is reported.

## Timing
- Request to grant: a request sampled in IDLE at edge t gives `grant` high after edge t (1-cycle latency).
- Release to drop: release sampled at edge t gives `grant` low after edge t.
- Minimum gap: at least one cycle with `grant`=0 between any two ownerships.
- Earliest new grant is one cycle after the drop.
- Minimum ownership: 1 cycle. `done` sampled on the first grant cycle releases immediately.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro: `RR_ARB_HOLD_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter loads 1 on entry to BUSY and increments each BUSY cycle.
  - When the counter equals `MAX_HOLD` and there is no release in that cycle: `grant` drops next cycle, `timeout` pulses high in that same first grant-low cycle, and the pointer advances exactly as for a release.
  - Release and limit in the same cycle count as a normal release, and `timeout` stays 0.
- Not defined:
  - No counter.
  - `timeout` is tied to 0.
  - Ownership is unbounded.

## Structure
- Package `rr_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - the `IDW` width function (clog2 with a minimum of 1);
  - the hold-counter width constant.
- Sub-module `rr_pick`:
  - purely combinational;
  - inputs: `req`, `ptr`;
  - outputs: one-hot winner, winner index, any-request flag;
  - implemented as rotate, fixed priority, rotate back.
- Top level holds the FSM, pointer, output registers and the optional counter.

## Test plan
- Reset then `req`=4'b1111 held, each owner pulsing `done` on its first cycle: grants 0001,0000,0010,0000,0100,0000,1000,0000,0001…
- `ptr`=2 (after owner 1), `req`=4'b0011: grant 0001 (wrap-around search), `grant_id`=0.
- Owner 1 holding, `req` then 4'b1111 for 10 cycles with no `done`: `grant` stays 0010 throughout. `done[3]` pulses are ignored.
- Owner 2 drops `req[2]` without `done`: `grant`=0 the next cycle. Next winner is 3 if `req[3]` is set, otherwise the first set bit after 3.
- With `RR_ARB_HOLD_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=4'b0001 held with no `done`: grant high for exactly 4 cycles, then 1 cycle low with `timeout`=1, then regranted to requester 0.
- `rst_an`=0 for one edge mid-ownership: all outputs 0 on the next cycle. A request sampled in the following IDLE cycle arbitrates from `ptr`=0.
